// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the unified-memory SRAM arbiter: response owner tags.
package sram_arbiter_pkg;

  localparam int ARB_OWN_WD = 2;

  typedef enum logic [ARB_OWN_WD-1:0] {
    ARB_OWN_NONE = 2'd0,
    ARB_OWN_INST = 2'd1,
    ARB_OWN_DATA = 2'd2
  } arb_own_e;

endpackage

// File: rtl/sram_arbiter_starve_ctr.sv
// Saturating count of consecutive data-over-inst wins; clear dominates increment.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max = (cnt_q == CNT_W'(STARVE_MAX));
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM shared by fetch (inst reads) and exe (data reads/writes);
// data has priority, fetch is guaranteed a slot after STARVE_MAX lost cycles.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_flush,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic             starve_max;
  logic [CNT_W-1:0] starve_cnt;
  arb_own_e         own_q;
  arb_own_e         own_d;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (data_gnt & inst_req),
    .clr    (inst_gnt | ~inst_req),
    .cnt    (starve_cnt),
    .at_max (starve_max)
  );

  // Grant: data wins unless fetch has already lost STARVE_MAX times in a row.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      if (data_req && !(inst_req && starve_max)) begin
        data_gnt = 1'b1;
      end else if (inst_req) begin
        inst_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_we    = data_we;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  always_comb begin
    own_d = ARB_OWN_NONE;
    if (inst_gnt && !inst_flush) begin
      own_d = ARB_OWN_INST;
    end else if (data_gnt && (data_we == '0)) begin
      own_d = ARB_OWN_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q <= ARB_OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  // Reset gates the response combinationally so an in-flight read is dropped.
  always_comb begin
    inst_rvalid = (own_q == ARB_OWN_INST) && !inst_flush && !reset;
    data_rvalid = (own_q == ARB_OWN_DATA) && !reset;
    inst_rdata  = inst_rvalid ? sram_rdata : '0;
    data_rdata  = data_rvalid ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized and directed bench for sram_arbiter against a transaction-level model.
module tb_sram_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_flush, inst_gnt, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_gnt, data_rvalid;
  logic [3:0]  data_we, sram_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sram_en;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  // model state: consecutive fetch losses, and who receives the next response
  int m_losses = 0;
  int m_resp   = 0;   // 0 none, 1 fetch, 2 exe

  logic        e_ig, e_dg;
  logic        o_ig, o_dg, o_irv, o_drv;
  logic [3:0]  o_we;
  logic [31:0] o_ird;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model at the edge.
  task automatic cyc(input logic r, input logic ireq, input logic [31:0] iaddr,
                     input logic fl, input logic dreq, input logic [3:0] dwe,
                     input logic [31:0] daddr, input logic [31:0] dwd,
                     input logic [31:0] srd);
    logic        x_irv, x_drv;
    logic [3:0]  x_we;
    logic [31:0] x_addr, x_wd;
    reset = r; inst_req = ireq; inst_addr = iaddr; inst_flush = fl;
    data_req = dreq; data_we = dwe; data_addr = daddr; data_wdata = dwd;
    sram_rdata = srd;
    #4;
    e_ig = 1'b0; e_dg = 1'b0;
    if (!r) begin
      if (dreq && ireq) begin
        if (m_losses >= SMAX) e_ig = 1'b1; else e_dg = 1'b1;
      end else begin
        e_dg = dreq;
        e_ig = ireq;
      end
    end
    x_we   = e_dg ? dwe   : 4'h0;
    x_addr = e_dg ? daddr : (e_ig ? iaddr : 32'h0);
    x_wd   = e_dg ? dwd   : 32'h0;
    x_irv  = !r && (m_resp == 1) && !fl;
    x_drv  = !r && (m_resp == 2);
    o_ig = inst_gnt; o_dg = data_gnt; o_we = sram_we;
    o_irv = inst_rvalid; o_drv = data_rvalid; o_ird = inst_rdata;
    chk("inst_gnt", 32'(inst_gnt), 32'(e_ig));
    chk("data_gnt", 32'(data_gnt), 32'(e_dg));
    chk("sram_en", 32'(sram_en), 32'(e_ig | e_dg));
    chk("sram_we", 32'(sram_we), 32'(x_we));
    chk("sram_addr", sram_addr, x_addr);
    chk("sram_wdata", sram_wdata, x_wd);
    chk("inst_rvalid", 32'(inst_rvalid), 32'(x_irv));
    chk("inst_rdata", inst_rdata, x_irv ? srd : 32'h0);
    chk("data_rvalid", 32'(data_rvalid), 32'(x_drv));
    chk("data_rdata", data_rdata, x_drv ? srd : 32'h0);
    @(posedge clk);
    if (r) begin
      m_losses = 0;
      m_resp   = 0;
    end else begin
      if (e_ig && !fl)              m_resp = 1;
      else if (e_dg && dwe == 4'h0) m_resp = 2;
      else                          m_resp = 0;
      if (e_ig || !ireq)            m_losses = 0;
      else if (e_dg && m_losses < SMAX) m_losses = m_losses + 1;
    end
    #1;
  endtask

  initial begin
    string       seq;
    int          pulses;
    logic        ip, dp;
    logic [31:0] ia, da, dw;
    logic [3:0]  dwe;
    seq = "DDDDIDDD";
    reset = 1'b1; inst_req = 0; inst_addr = 0; inst_flush = 0; data_req = 0;
    data_we = 0; data_addr = 0; data_wdata = 0; sram_rdata = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h40, 0, 1, 4'h0, 32'h80, 32'h1, 32'h5555);

    // 1: fetch alone, read data returned the next cycle
    cyc(0, 1, 32'h1c000000, 0, 0, 4'h0, 0, 0, 32'h0);
    chk("t1_gnt", 32'(o_ig), 32'h1);
    cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h02800000);
    chk("t1_rvalid", 32'(o_irv), 32'h1);
    chk("t1_rdata", o_ird, 32'h02800000);

    // 2: data read then data write back-to-back
    pulses = 0;
    cyc(0, 0, 0, 0, 1, 4'h0, 32'h100, 32'h0, 32'h11);
    chk("t2_we_rd", 32'(o_we), 32'h0);
    pulses += int'(o_drv);
    cyc(0, 0, 0, 0, 1, 4'hf, 32'h104, 32'hdeadbeef, 32'h22);
    chk("t2_we_wr", 32'(o_we), 32'hf);
    pulses += int'(o_drv);
    cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h33);
    pulses += int'(o_drv);
    cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h44);
    pulses += int'(o_drv);
    chk("t2_pulses", 32'(pulses), 32'd1);

    // 3: both held for 8 cycles
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 32'h2000, 0, 1, 4'h0, 32'h3000, 0, 32'(i));
      chk("t3_seq", {30'h0, o_ig, o_dg}, (seq[i] == "D") ? 32'h1 : 32'h2);
      chk("t3_excl", 32'(o_ig & o_dg), 32'h0);
    end
    cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0);

    // 4: flush in the response cycle, then in the grant cycle
    cyc(0, 1, 32'h500, 0, 0, 4'h0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 0, 4'h0, 0, 0, 32'habc);
    chk("t4_flush_resp", 32'(o_irv), 32'h0);
    cyc(0, 1, 32'h504, 1, 0, 4'h0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, 32'habd);
    chk("t4_flush_gnt", 32'(o_irv), 32'h0);

    // 5: reset right after a data read grant, grant on release
    cyc(0, 0, 0, 0, 1, 4'h0, 32'h200, 0, 32'h0);
    cyc(1, 1, 32'h600, 0, 1, 4'h0, 32'h204, 0, 32'h77);
    chk("t5_no_rvalid", 32'(o_drv), 32'h0);
    cyc(0, 1, 32'h600, 0, 1, 4'h0, 32'h204, 0, 32'h78);
    chk("t5_first_gnt", 32'(o_dg), 32'h1);
    cyc(0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h79);

    // random traffic: requests held until the model says they were granted
    ip = 0; dp = 0; ia = 0; da = 0; dw = 0; dwe = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ip && ($urandom_range(0, 2) != 0)) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && ($urandom_range(0, 2) != 0)) begin
        dp = 1; da = $urandom; dw = $urandom;
        dwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      cyc(($urandom_range(0, 49) == 0), ip, ia, ($urandom_range(0, 6) == 0),
          dp, dwe, da, dw, $urandom);
      if (e_ig) ip = 0;
      if (e_dg) dp = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
